// File: rtl/vaccine_hit_detector.sv
`default_nettype none
// ============================================================================
//  Module      : vaccine_hit_detector
//  Description : Watches the per-pixel drawing requests of the clamp and the
//                vaccines during scan-out. It captures the first clamp/vaccine
//                overlap of a frame and reports it as a one-cycle pulse just
//                after the next startOfFrame. After a report, the reported
//                vaccine is ignored for a few frames. A saturating count of
//                reported hits feeds the score logic.
//  Ports       : clk                     - system clock
//                reset                   - synchronous, active-high reset
//                startOfFrame            - one-cycle pulse at each frame start
//                clamp_dr                - clamp drawing request, current pixel
//                vaccine_dr              - per-vaccine drawing request
//                vaccine_visible         - per-vaccine visibility feedback
//                collision               - one-cycle pulse when a hit is reported
//                collision_clamp_vaccine - index of the last reported vaccine
//                hit_pending             - a hit is captured and waits for the
//                                          frame boundary
//                hit_count               - saturating count of reported hits
//  Revision    : 1.0 - initial release
// ============================================================================
module vaccine_hit_detector #(
  parameter int NUM_VACCINES    = 10,
  parameter int COOLDOWN_FRAMES = 2,
  parameter int COUNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic                    clamp_dr,
  input  logic [0:NUM_VACCINES-1] vaccine_dr,
  input  logic [0:NUM_VACCINES-1] vaccine_visible,
  output logic                    collision,
  output logic [3:0]              collision_clamp_vaccine,
  output logic                    hit_pending,
  output logic [COUNT_W-1:0]      hit_count
);

  // The cooldown counter is sized to hold COOLDOWN_FRAMES. It keeps at least
  // one bit so that COOLDOWN_FRAMES = 0 still elaborates.
  localparam int             CD_W    = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURED = 2'd1,
    EMIT     = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              cap_idx;
  logic [3:0]              cool_idx;
  logic [CD_W-1:0]         cool_cnt;

  logic [0:NUM_VACCINES-1] cool_mask;
  logic [0:NUM_VACCINES-1] hv;
  logic                    hit_any;
  logic [3:0]              hit_idx;

  // Only the most recently reported vaccine is masked, and only while the
  // cooldown is still running.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_VACCINES; gi++) begin : g_mask
      assign cool_mask[gi] = (cool_cnt != '0) && (cool_idx == 4'(gi));
    end
  endgenerate

  assign hv = clamp_dr ? (vaccine_dr & vaccine_visible & ~cool_mask) : '0;

  // Lowest index wins. The scan runs downward, so the last assignment is
  // the lowest set bit.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = 4'd0;
    for (int i = NUM_VACCINES - 1; i >= 0; i--) begin
      if (hv[i]) begin
        hit_any = 1'b1;
        hit_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= IDLE;
      cap_idx                 <= 4'd0;
      cool_idx                <= 4'd0;
      cool_cnt                <= '0;
      collision               <= 1'b0;
      collision_clamp_vaccine <= 4'd0;
      hit_pending             <= 1'b0;
      hit_count               <= '0;
    end else begin
      collision <= 1'b0;

      // Frame-based decrement. A load in EMIT (below) overrides this
      // assignment because it comes later.
      if (startOfFrame && (cool_cnt != '0)) begin
        cool_cnt <= cool_cnt - 1'b1;
      end

      case (state)
        IDLE: begin
          // An overlap seen in the startOfFrame cycle falls in blanking
          // and is not captured.
          if (!startOfFrame && hit_any) begin
            cap_idx     <= hit_idx;
            hit_pending <= 1'b1;
            state       <= CAPTURED;
          end
        end

        CAPTURED: begin
          if (startOfFrame) begin
            collision_clamp_vaccine <= cap_idx;
            collision               <= 1'b1;
            hit_pending             <= 1'b0;
            state                   <= EMIT;
          end
        end

        EMIT: begin
          if (hit_count != '1) begin
            hit_count <= hit_count + 1'b1;
          end
          cool_idx <= cap_idx;
          cool_cnt <= CD_LOAD;
          // The overlap test in this cycle still uses the previous mask.
          if (hit_any) begin
            cap_idx     <= hit_idx;
            hit_pending <= 1'b1;
            state       <= CAPTURED;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vaccine_hit_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vaccine_hit_detector
//  Description : Self-checking bench for vaccine_hit_detector. Directed
//                vectors exercise the corner cases. A randomized phase is
//                compared against a behavioural model. A second instance
//                with a 2-bit counter covers saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vaccine_hit_detector;

  localparam int NV = 10;
  localparam int CD = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          sof;
  logic          clamp;
  logic [0:NV-1] vdr;
  logic [0:NV-1] vvis;

  logic          coll_a, pend_a, coll_b, pend_b;
  logic [3:0]    idx_a, idx_b;
  logic [7:0]    cnt_a;
  logic [1:0]    cnt_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vaccine_hit_detector #(.NUM_VACCINES(NV), .COOLDOWN_FRAMES(CD), .COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .clamp_dr(clamp),
    .vaccine_dr(vdr), .vaccine_visible(vvis),
    .collision(coll_a), .collision_clamp_vaccine(idx_a),
    .hit_pending(pend_a), .hit_count(cnt_a)
  );

  vaccine_hit_detector #(.NUM_VACCINES(NV), .COOLDOWN_FRAMES(CD), .COUNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .startOfFrame(sof), .clamp_dr(clamp),
    .vaccine_dr(vdr), .vaccine_visible(vvis),
    .collision(coll_b), .collision_clamp_vaccine(idx_b),
    .hit_pending(pend_b), .hit_count(cnt_b)
  );

  // ---------------------------------------------------------------------
  // Behavioural model: one pending hit per frame, reported on the cycle
  // after the frame boundary, with a frame-counted cooldown on the
  // reported index.
  // ---------------------------------------------------------------------
  bit m_pend, m_coll;
  int m_pidx, m_idx, m_cnt, m_cnt2, m_cool, m_cidx, m_low;

  always @(posedge clk) begin
    if (reset) begin
      m_pend = 0; m_coll = 0; m_pidx = 0; m_idx = 0;
      m_cnt = 0; m_cnt2 = 0; m_cool = 0; m_cidx = 0;
    end else begin
      m_low = -1;
      for (int i = 0; i < NV; i++) begin
        if (m_low < 0 && clamp && vdr[i] && vvis[i] && !(m_cool > 0 && m_cidx == i)) m_low = i;
      end
      if (m_coll) begin
        m_coll = 0;
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
        m_cidx = m_idx;
        m_cool = CD;
        m_pend = (m_low >= 0);
        if (m_low >= 0) m_pidx = m_low;
      end else begin
        if (sof && m_cool > 0) m_cool--;
        if (m_pend) begin
          if (sof) begin m_coll = 1; m_idx = m_pidx; m_pend = 0; end
        end else if (!sof && m_low >= 0) begin
          m_pend = 1; m_pidx = m_low;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  typedef struct {
    bit          rst, s, c;
    bit [0:NV-1] dr, vis;
    bit          e_coll, e_pend;
    int          e_idx, e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic bit [0:NV-1] bits2(int a, int b);
    bit [0:NV-1] v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction

  task automatic add(bit rst, bit s, bit c, bit [0:NV-1] dr, bit [0:NV-1] vis,
                     bit e_coll, int e_idx, bit e_pend, int e_cnt);
    vec_t r;
    r.rst = rst; r.s = s; r.c = c; r.dr = dr; r.vis = vis;
    r.e_coll = e_coll; r.e_idx = e_idx; r.e_pend = e_pend; r.e_cnt = e_cnt;
    tbl.push_back(r);
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit rst, bit s, bit c, bit [0:NV-1] dr, bit [0:NV-1] vis);
    reset = rst; sof = s; clamp = c; vdr = dr; vvis = vis;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit [0:NV-1] all1, no1, z;

  initial begin
    all1 = '1;
    z    = '0;
    no1  = '1;
    no1[1] = 1'b0;
    drive(1, 0, 0, z, z);

    //   rst sof clamp dr            vis   coll idx pend cnt
    add(1, 0, 0, z,            all1, 0, 0, 0, 0);
    add(0, 0, 0, z,            all1, 0, 0, 0, 0);
    add(0, 0, 1, bits2(3, -1), all1, 0, 0, 1, 0);  // capture 3
    add(0, 0, 0, z,            all1, 0, 0, 1, 0);
    add(0, 1, 0, z,            all1, 1, 3, 0, 0);  // pulse one cycle after sof
    add(0, 0, 0, z,            all1, 0, 3, 0, 1);
    add(0, 0, 1, bits2(3, -1), all1, 0, 3, 0, 1);  // 3 masked (cooldown 2)
    add(0, 1, 0, z,            all1, 0, 3, 0, 1);
    add(0, 0, 1, bits2(3, -1), all1, 0, 3, 0, 1);  // still masked (cooldown 1)
    add(0, 1, 0, z,            all1, 0, 3, 0, 1);
    add(0, 0, 1, bits2(3, -1), all1, 0, 3, 1, 1);  // cooldown over: captured
    add(0, 1, 0, z,            all1, 1, 3, 0, 1);
    add(0, 0, 0, z,            all1, 0, 3, 0, 2);
    add(0, 0, 1, bits2(6, -1), all1, 0, 3, 1, 2);  // 6 unaffected by cooldown
    add(0, 1, 0, z,            all1, 1, 6, 0, 2);
    add(0, 0, 0, z,            all1, 0, 6, 0, 3);
    add(0, 0, 1, bits2(5, -1), all1, 0, 6, 1, 3);  // 5 first in frame
    add(0, 0, 1, bits2(2, -1), all1, 0, 6, 1, 3);  // 2 discarded
    add(0, 1, 0, z,            all1, 1, 5, 0, 3);
    add(0, 0, 0, z,            all1, 0, 5, 0, 4);
    add(0, 0, 1, bits2(7, 4),  all1, 0, 5, 1, 4);  // lowest index wins
    add(0, 1, 0, z,            all1, 1, 4, 0, 4);
    add(0, 0, 0, z,            all1, 0, 4, 0, 5);
    add(0, 0, 1, bits2(1, -1), no1,  0, 4, 0, 5);  // hidden vaccine
    add(0, 1, 0, z,            all1, 0, 4, 0, 5);
    add(0, 1, 1, bits2(1, -1), all1, 0, 4, 0, 5);  // overlap only in sof cycle
    add(0, 0, 0, z,            all1, 0, 4, 0, 5);
    add(0, 0, 0, bits2(8, -1), all1, 0, 4, 0, 5);  // no clamp request
    add(0, 0, 1, bits2(8, -1), all1, 0, 4, 1, 5);  // pending ...
    add(1, 0, 0, z,            all1, 0, 0, 0, 0);  // ... dropped by reset
    add(0, 1, 0, z,            all1, 0, 0, 0, 0);
    add(0, 0, 0, z,            all1, 0, 0, 0, 0);
    add(0, 0, 1, bits2(2, -1), all1, 0, 0, 1, 0);
    add(0, 1, 0, z,            all1, 1, 2, 0, 0);
    add(0, 0, 1, bits2(2, -1), all1, 0, 2, 1, 1);  // re-capture during EMIT (old mask)
    add(0, 1, 0, z,            all1, 1, 2, 0, 1);
    add(0, 0, 0, z,            all1, 0, 2, 0, 2);

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].s, tbl[k].c, tbl[k].dr, tbl[k].vis);
      step();
      chk($sformatf("vec%0d collision", k),   int'(coll_a), int'(tbl[k].e_coll));
      chk($sformatf("vec%0d index", k),       int'(idx_a),  tbl[k].e_idx);
      chk($sformatf("vec%0d hit_pending", k), int'(pend_a), int'(tbl[k].e_pend));
      chk($sformatf("vec%0d hit_count", k),   int'(cnt_a),  tbl[k].e_cnt);
      chk($sformatf("vec%0d sat_count", k),   int'(cnt_b),
          (tbl[k].e_cnt > 3) ? 3 : tbl[k].e_cnt);
    end

    // Randomized phase against the model.
    drive(1, 0, 0, z, all1);
    step();
    for (int n = 0; n < 3000; n++) begin
      bit [0:NV-1] d, v;
      for (int i = 0; i < NV; i++) begin
        d[i] = ($urandom_range(0, 7) == 0);
        v[i] = ($urandom_range(0, 7) != 0);
      end
      drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 1) == 1), d, v);
      step();
      chk("rnd collision",   int'(coll_a), int'(m_coll));
      chk("rnd index",       int'(idx_a),  m_idx);
      chk("rnd hit_pending", int'(pend_a), int'(m_pend));
      chk("rnd hit_count",   int'(cnt_a),  m_cnt);
      chk("rnd sat_count",   int'(cnt_b),  m_cnt2);
      chk("rnd sat_index",   int'(idx_b),  m_idx);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
